pipe_ctrl: RTL and testbench

Hazard and redirect controller for the 3-stage (Fetch / Decode-Execute / Writeback) pipeline. It sequences the fetch-decode pipeline buffer and the decode-writeback buffer. It decides each cycle whether the PC and buffers advance, hold (stall) or are flushed to NOP, and selects the next-PC source. Sources are taken branches, `mret`, a multi-cycle data memory, and trap entry, including a data-memory wait timeout.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_perf_cnt.sv | 28 ++
 rtl/pipe_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
// Optional performance counters are enabled by defining PIPE_PERF_EN.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN           = 2'd0,
        MEM_WAIT      = 2'd1,
        TRAP_FLUSH    = 2'd2,
        TRAP_REDIRECT = 2'd3
    } pipe_state_e;

    typedef enum logic {
        CAUSE_EXT      = 1'b0,
        CAUSE_MEM_TOUT = 1'b1
    } trap_cause_e;

    // Canonical NOP (addi x0, x0, 0) loaded into flushed pipeline buffers.
    localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Wrap-around event counters for stalls, flushes and trap entries.
// Instantiated by pipe_ctrl only when PIPE_PERF_EN is defined.
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_ev,
    input  logic             flush_ev,
    input  logic             trap_ev,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] trap_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            trap_cnt  <= '0;
        end else begin
            if (stall_ev) stall_cnt <= stall_cnt + 1'b1;
            if (flush_ev) flush_cnt <= flush_cnt + 1'b1;
            if (trap_ev)  trap_cnt  <= trap_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and redirect controller for the 3-stage F / DE / W pipeline.
// Define PIPE_PERF_EN to add the stall/flush/trap performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_taken_d,
    input  logic [XLEN-1:0] br_target_d,
    input  logic            mret_d,
    input  logic [XLEN-1:0] mepc,
    input  logic            dmem_busy,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
    output logic            stall_pc,
    output logic            stall_fd,
    output logic            flush_fd,
    output logic            flush_dw,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            trap_ack,
    output logic            trap_cause,
    output pipe_state_e     dbg_state
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] trap_cnt
`endif
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    pipe_state_e       state;
    logic [WAIT_W-1:0] wait_cnt;
    trap_cause_e       cause_q;

    logic            br_any;
    logic [XLEN-1:0] br_tgt;

    // mret wins over a branch resolved in the same cycle.
    assign br_any = mret_d | br_taken_d;
    assign br_tgt = mret_d ? mepc : br_target_d;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            cause_q  <= CAUSE_EXT;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end else if (trap_req) begin
                        state   <= TRAP_FLUSH;
                        cause_q <= CAUSE_EXT;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_busy) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt >= WAIT_LAST) begin
                            state   <= TRAP_FLUSH;
                            cause_q <= CAUSE_MEM_TOUT;
                        end
                    end
                end
                TRAP_FLUSH: begin
                    state <= TRAP_REDIRECT;
                end
                TRAP_REDIRECT: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall_pc    = 1'b0;
        stall_fd    = 1'b0;
        flush_fd    = 1'b0;
        flush_dw    = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        trap_ack    = 1'b0;
        trap_cause  = 1'b0;
        case (state)
            RUN: begin
                if (dmem_busy) begin
                    stall_pc = 1'b1;
                    stall_fd = 1'b1;
                end else if (!trap_req && br_any) begin
                    flush_fd    = 1'b1;
                    pc_redirect = 1'b1;
                    pc_target   = br_tgt;
                end
            end
            MEM_WAIT: begin
                // On the release cycle the D/E stage unfreezes, so its branch is acted on now.
                if (dmem_busy) begin
                    stall_pc = 1'b1;
                    stall_fd = 1'b1;
                end else if (br_any) begin
                    flush_fd    = 1'b1;
                    pc_redirect = 1'b1;
                    pc_target   = br_tgt;
                end
            end
            TRAP_FLUSH: begin
                flush_fd = 1'b1;
                flush_dw = 1'b1;
                stall_pc = 1'b1;
            end
            TRAP_REDIRECT: begin
                pc_redirect = 1'b1;
                pc_target   = trap_vec;
                trap_ack    = 1'b1;
                trap_cause  = cause_q;
            end
            default: begin
                stall_pc = 1'b0;
            end
        endcase
    end

`ifdef PIPE_PERF_EN
    pipe_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk      (clk),
        .rst      (rst),
        .stall_ev (stall_fd),
        .flush_ev (flush_fd),
        .trap_ev  (trap_ack),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
        .trap_cnt (trap_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with MAX_WAIT = 4; counter checks apply when
// PIPE_PERF_EN is defined.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            br_taken_d;
    logic [XLEN-1:0] br_target_d;
    logic            mret_d;
    logic [XLEN-1:0] mepc;
    logic            dmem_busy;
    logic            trap_req;
    logic [XLEN-1:0] trap_vec;
    logic            stall_pc, stall_fd, flush_fd, flush_dw;
    logic            pc_redirect, trap_ack, trap_cause;
    logic [XLEN-1:0] pc_target;
    pipe_state_e     dbg_state;
`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt, trap_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(
        .XLEN(XLEN), .MAX_WAIT(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .br_taken_d(br_taken_d), .br_target_d(br_target_d),
        .mret_d(mret_d), .mepc(mepc),
        .dmem_busy(dmem_busy), .trap_req(trap_req), .trap_vec(trap_vec),
        .stall_pc(stall_pc), .stall_fd(stall_fd),
        .flush_fd(flush_fd), .flush_dw(flush_dw),
        .pc_redirect(pc_redirect), .pc_target(pc_target),
        .trap_ack(trap_ack), .trap_cause(trap_cause),
        .dbg_state(dbg_state)
`ifdef PIPE_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .trap_cnt(trap_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // flags = {stall_pc, stall_fd, flush_fd, flush_dw, pc_redirect, trap_ack, trap_cause}
    task automatic expect_outs(input string tag, input logic [6:0] flags,
                               input logic [31:0] tgt, input pipe_state_e st);
        #3;
        check({tag, ".flags"}, 32'({stall_pc, stall_fd, flush_fd, flush_dw,
                                    pc_redirect, trap_ack, trap_cause}), 32'(flags));
        check({tag, ".target"}, pc_target, tgt);
        check({tag, ".state"}, 32'(dbg_state), 32'(st));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        br_taken_d  = 1'b0;
        br_target_d = '0;
        mret_d      = 1'b0;
        mepc        = '0;
        dmem_busy   = 1'b0;
        trap_req    = 1'b0;
        trap_vec    = '0;
    endtask

    localparam logic [6:0] F_NONE  = 7'b0000000;
    localparam logic [6:0] F_STALL = 7'b1100000;
    localparam logic [6:0] F_BR    = 7'b0010100;
    localparam logic [6:0] F_TFL   = 7'b1011000;
    localparam logic [6:0] F_ACK0  = 7'b0000110;
    localparam logic [6:0] F_ACK1  = 7'b0000111;

    initial begin
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        expect_outs("reset", F_NONE, 32'h0, RUN);
`ifdef PIPE_PERF_EN
        check("reset.stall_cnt", stall_cnt, 32'd0);
        check("reset.flush_cnt", flush_cnt, 32'd0);
        check("reset.trap_cnt", trap_cnt, 32'd0);
`endif
        cyc();

        // Taken branch, then mret overriding a simultaneous branch.
        br_taken_d = 1'b1; br_target_d = 32'h100;
        expect_outs("branch", F_BR, 32'h100, RUN);
        cyc();
        mret_d = 1'b1; mepc = 32'h80;
        expect_outs("mret_prio", F_BR, 32'h80, RUN);
        cyc();
        idle_inputs();
        expect_outs("after_br", F_NONE, 32'h0, RUN);
        cyc();

        // Three busy cycles with a branch held: stall, then redirect on release.
        br_taken_d = 1'b1; br_target_d = 32'h140; dmem_busy = 1'b1;
        expect_outs("busy1", F_STALL, 32'h0, RUN);
        cyc();
        expect_outs("busy2", F_STALL, 32'h0, MEM_WAIT);
        cyc();
        expect_outs("busy3", F_STALL, 32'h0, MEM_WAIT);
        cyc();
        dmem_busy = 1'b0;
        expect_outs("busy_rel", F_BR, 32'h140, MEM_WAIT);
        cyc();
        idle_inputs();
        expect_outs("busy_done", F_NONE, 32'h0, RUN);
        cyc();

        // External trap with a branch present: branch ignored throughout.
        trap_req = 1'b1; trap_vec = 32'h200; br_taken_d = 1'b1; br_target_d = 32'h300;
        expect_outs("trap_n0", F_NONE, 32'h0, RUN);
        cyc();
        expect_outs("trap_n1", F_TFL, 32'h0, TRAP_FLUSH);
        cyc();
        expect_outs("trap_n2", F_ACK0, 32'h200, TRAP_REDIRECT);
        trap_req = 1'b0; br_taken_d = 1'b0;
        cyc();
        expect_outs("trap_n3", F_NONE, 32'h0, RUN);
        cyc();

        // Stuck dmem_busy: timeout trap, trap_req ignored while waiting.
        dmem_busy = 1'b1; trap_vec = 32'h240;
        expect_outs("tout_n0", F_STALL, 32'h0, RUN);
        cyc();
        trap_req = 1'b1;
        expect_outs("tout_n1", F_STALL, 32'h0, MEM_WAIT);
        cyc();
        expect_outs("tout_n2", F_STALL, 32'h0, MEM_WAIT);
        cyc();
        trap_req = 1'b0;
        expect_outs("tout_n3", F_STALL, 32'h0, MEM_WAIT);
        cyc();
        expect_outs("tout_n4", F_TFL, 32'h0, TRAP_FLUSH);
        cyc();
        expect_outs("tout_n5", F_ACK1, 32'h240, TRAP_REDIRECT);
        dmem_busy = 1'b0;
        cyc();
        expect_outs("tout_n6", F_NONE, 32'h0, RUN);
`ifdef PIPE_PERF_EN
        check("perf.stall_cnt", stall_cnt, 32'd7);
        check("perf.flush_cnt", flush_cnt, 32'd5);
        check("perf.trap_cnt", trap_cnt, 32'd2);
`endif
        cyc();

        // Reset during TRAP_FLUSH: no ack, back to RUN with quiet outputs.
        trap_req = 1'b1; trap_vec = 32'h280;
        expect_outs("rst_n0", F_NONE, 32'h0, RUN);
        cyc();
        expect_outs("rst_n1", F_TFL, 32'h0, TRAP_FLUSH);
        rst = 1'b1; trap_req = 1'b0;
        cyc();
        rst = 1'b0;
        expect_outs("rst_n2", F_NONE, 32'h0, RUN);
`ifdef PIPE_PERF_EN
        check("rst.flush_cnt", flush_cnt, 32'd0);
`endif
        cyc();
        expect_outs("rst_n3", F_NONE, 32'h0, RUN);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
